// File: rtl/i2c_mem_wb_arbiter.sv
// i2c_mem_wb_arbiter: round-robin two-master Wishbone B3 arbiter for the I2C test memory; I2C_MEM_ARB_TIMEOUT_EN adds a stall abort
module i2c_mem_wb_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [2:0]    m0_cti_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [2:0]    m1_cti_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic [2:0]    s_cti_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    gnt_o
);
  typedef enum logic [1:0] {
    IDLE, GNT0, GNT1
`ifdef I2C_MEM_ARB_TIMEOUT_EN
    , ABORT
`endif
  } state_t;
  state_t state;
  logic last;
  logic g0;
  logic g1;
  logic to;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  always_comb begin
    s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
    s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
    s_we_o  = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
    s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
    s_stb_o = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
    s_cti_o = g0 ? m0_cti_i : g1 ? m1_cti_i : 3'b111;
  end
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & s_ack_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m0_err_o = g0 & (s_err_i | to);
  assign m1_err_o = g1 & (s_err_i | to);
`ifdef I2C_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1) > 4 ? $clog2(TIMEOUT + 1) : 4;
  logic [CW-1:0] cnt;
  logic stall;
  assign stall = s_stb_o & ~s_ack_i & ~s_err_i;
  // the current stalled cycle counts, so the abort lands on stall cycle TIMEOUT
  assign to = stall && (cnt + 1'b1) == CW'(TIMEOUT);
  always_ff @(posedge clk_i)
    cnt <= (rst_i || !stall) ? '0 : cnt + 1'b1;
`else
  assign to = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_o <= 2'b00;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= GNT0;
            gnt_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state <= GNT1;
            gnt_o <= 2'b10;
          end
        GNT0:
          if (!m0_cyc_i) begin
            state <= IDLE;
            gnt_o <= 2'b00;
            last  <= 1'b0;
          end
`ifdef I2C_MEM_ARB_TIMEOUT_EN
          else if (to) state <= ABORT;
`endif
        GNT1:
          if (!m1_cyc_i) begin
            state <= IDLE;
            gnt_o <= 2'b00;
            last  <= 1'b1;
          end
`ifdef I2C_MEM_ARB_TIMEOUT_EN
          else if (to) state <= ABORT;
        ABORT:
          if (!(gnt_o[1] ? m1_cyc_i : m0_cyc_i)) begin
            state <= IDLE;
            gnt_o <= 2'b00;
            last  <= gnt_o[1];
          end
`endif
        default: begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: doc/i2c_mem_wb_arbiter.md
# i2c_mem_wb_arbiter

Two-master Wishbone B3 arbiter that shares the 8-bit I2C-side test memory (a `ram_wb_b3` instance) between two masters. Master 0 is the I2C byte-stream write sequencer. Master 1 is a bench/debug reader. The block sits directly in front of the memory slave port: requesters connect to `m0_*` / `m1_*`, and the memory connects to `s_*`. Grants are round-robin. A grant is held for the whole `cyc` tenure, so classic and incrementing bursts are never split.

## Interface
Parameters:
- `AW`, 8: address width.
- `DW`, 8: data width.
- `TIMEOUT`, 15: maximum wait cycles (stb high, no ack/err) before abort. Used only with `I2C_MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: single clock; everything is posedge.
- `rst_i` in 1: reset, synchronous, active-high.
- `m0_adr_i` / `m1_adr_i` in AW; `m0_dat_i` / `m1_dat_i` in DW: master address and write data.
- `m0_we_i`, `m0_cyc_i`, `m0_stb_i` / `m1_*` same, in 1: master controls.
- `m0_cti_i` / `m1_cti_i` in 3: cycle type, passed through.
- `m0_dat_o` / `m1_dat_o` out DW: read data, both driven from `s_dat_i`.
- `m0_ack_o`, `m0_err_o` / `m1_*` out 1: terminations, routed to the granted master only.
- `s_adr_o` out AW, `s_dat_o` out DW, `s_we_o`, `s_cyc_o`, `s_stb_o` out 1, `s_cti_o` out 3: slave request bus.
- `s_dat_i` in DW, `s_ack_i`, `s_err_i` in 1: slave responses.
- `gnt_o` out 2: one-hot current grant; `2'b00` when idle.

## Operation
- States: IDLE, GNT0, GNT1, ABORT (ABORT exists only with the macro).
- IDLE:
  - Only `m0_cyc_i` high → GNT0. Only `m1_cyc_i` high → GNT1.
  - Both high → the master not granted last wins.
  - `last` register resets to 1, so m0 wins the first tie.
- GNTn:
  - `s_*` request outputs follow master n combinationally.
  - `s_ack_i` / `s_err_i` go to `mn_ack_o` / `mn_err_o`. The other master's ack/err stay 0.
  - When `mn_cyc_i` is low at a clock edge: → IDLE, and `last` ← n.
- In IDLE, and for the non-granted path: `s_cyc_o`, `s_stb_o`, `s_we_o` are 0; `s_adr_o`, `s_dat_o` are 0; `s_cti_o` is 3'b111.
- A request by the non-granted master is held off (no ack, no err) until re-arbitration. There is no preemption.
- `s_ack_i` / `s_err_i` arriving in IDLE are dropped.
- Reset at any point, including mid-burst: state IDLE, `gnt_o` 00, `last` 1, timeout counter 0. All outputs are at their IDLE values in the first cycle after the reset edge.

## Timing
- Arbitration latency: 1 cycle. `cyc` high at edge k gives a grant visible after edge k.
- Slave request and response paths through the grant mux are combinational; they add zero cycles to slave latency.
- Release costs 1 cycle: IDLE always appears between two tenures, including back-to-back requests from the same master.
- Simultaneous release by the holder and request by the other master: IDLE for 1 cycle, then the other master is granted.
- Back-to-back ack bursts (`cti` = 3'b010) pass through at full rate while granted.

## Configuration
- `I2C_MEM_ARB_TIMEOUT_EN` defined:
  - A 4-bit-minimum counter (width clog2(TIMEOUT+1)) clears on grant, on ack/err, and whenever `s_stb_o` is low.
  - It increments each cycle that `s_stb_o` is high with no `s_ack_i` / `s_err_i`.
  - When count = TIMEOUT: `mn_err_o` pulses high for 1 cycle, `s_cyc_o` / `s_stb_o` drop on the next cycle, and the state goes to ABORT.
  - ABORT: slave outputs at IDLE values; master acks/errs held 0. On `mn_cyc_i` low → IDLE, and `last` ← n.
- Undefined: no counter and no ABORT state. A non-responding slave holds the grant indefinitely.

## Test plan
- m0 single write (adr 0x10, dat 0xA5, slave acks 1 cycle after stb) → `gnt_o` = 01 one cycle after cyc; `m0_ack_o` pulses once; `m1_ack_o` stays 0; readback through m1 returns 0xA5.
- m0 and m1 raise cyc on the same edge, repeatedly, after reset → grants alternate 01, 00, 10, 00, 01, …
- m0 holds a 4-beat incrementing burst (cti 010, adr 0x20–0x23) while m1 requests → m1 is not granted until 1 cycle after m0 cyc falls; all 4 beats are acked to m0.
- `rst_i` asserted mid-burst while GNT1 → next cycle `gnt_o` = 00, `s_cyc_o` = 0, `s_cti_o` = 111; after release, simultaneous requests grant m0.
- Macro on, TIMEOUT = 15, slave never acks m1 → `m1_err_o` pulses on the 15th stall cycle; `s_stb_o` is 0 the next cycle; grant passes to a waiting m0 one cycle after m1 drops cyc.
- Stray `s_ack_i` pulse injected in IDLE → `m0_ack_o` = `m1_ack_o` = 0; state stays IDLE.
